// File: rtl/intc_multi_pkg.sv
// Shared definitions for the jacaranda-8 multi-source interrupt controller.
// Holds register offsets within the block's address window, the controller
// state encoding, and the cpu_int_en value used while the controller is idle.
package intc_multi_pkg;

  // Register offsets from BASE_ADDR; VEC[i] sits at OFS_VEC + i.
  localparam int unsigned OFS_MASK = 0;
  localparam int unsigned OFS_PEND = 1;
  localparam int unsigned OFS_ID   = 2;
  localparam int unsigned OFS_EOI  = 3;
  localparam int unsigned OFS_VEC  = 4;

  // Up to 8 sources, so a 3-bit id covers every index.
  localparam int unsigned ID_W = 3;

  localparam logic [7:0] CPU_INT_EN_ON = 8'h01;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
// Ports:
//   req  in  NUM_SRC  request vector (already masked by the caller)
//   any  out 1        at least one request bit set
//   id   out ID_W     index of the lowest set bit (0 when none set)
module intc_prio_enc
  import intc_multi_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  always_comb begin
    any = |req;
    id  = '0;
    // Scan high to low so the lowest set index is the last assignment.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/intc_multi.sv
// Memory-mapped interrupt controller for the jacaranda-8 CPU.
// Latches NUM_SRC peripheral requests into PEND, masks them with MASK, and
// presents the lowest-index pending source to the CPU. Software acknowledges
// by reading ID and retires the interrupt by writing EOI.
//
// Configuration macro: INTC_LEVEL_EN
//   undefined (default): edge mode, a rising src[i] sets PEND[i]; PEND bits are
//                        cleared by W1C writes or EOI of the active id.
//   defined:             level mode, PEND is a registered copy of src; EOI only
//                        returns the FSM to idle.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous, active-high reset
//   src          in   NUM_SRC peripheral request lines (synchronous to clock)
//   addr         in   CPU data address
//   w_data       in   CPU write data
//   w_en         in   store strobe
//   r_en         in   load strobe
//   r_data       out  register read data, combinational from addr, 0 when !hit
//   hit          out  addr falls inside BASE_ADDR..BASE_ADDR+3+NUM_SRC
//   cpu_int_req  out  interrupt request to the CPU
//   cpu_int_en   out  8'h01 when idle, 8'h00 otherwise
//   cpu_int_vec  out  handler address of the latched source
//
// Register map (offset from BASE_ADDR):
//   +0 MASK (R/W)  +1 PEND (R, W1C)  +2 ID (R)  +3 EOI (W)  +4+i VEC[i] (R/W)
module intc_multi
  import intc_multi_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 'hE0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  src,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic                w_en,
  input  logic                r_en,
  output logic [DATA_W-1:0]   r_data,
  output logic                hit,
  output logic                cpu_int_req,
  output logic [7:0]          cpu_int_en,
  output logic [DATA_W-1:0]   cpu_int_vec
);

  logic [ADDR_W-1:0]  off;
  logic               mask_we;
  logic               eoi_we;
  logic               id_rd;
  logic               valid;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [DATA_W-1:0]  vec_q [NUM_SRC];
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  vec_out_q;

  logic               win_any;
  logic [ID_W-1:0]    win_id;
  logic [DATA_W-1:0]  win_vec;

  // Address decode
  assign off     = addr - ADDR_W'(BASE_ADDR);
  assign hit     = (addr >= ADDR_W'(BASE_ADDR)) && (off < ADDR_W'(OFS_VEC + NUM_SRC));
  assign mask_we = w_en && hit && (off == ADDR_W'(OFS_MASK));
  assign eoi_we  = w_en && hit && (off == ADDR_W'(OFS_EOI));
  assign id_rd   = r_en && hit && (off == ADDR_W'(OFS_ID));

  // Arbitration
  intc_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req (pend_q & mask_q),
    .any (win_any),
    .id  (win_id)
  );

  always_comb begin
    win_vec = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (win_id == ID_W'(i)) win_vec = vec_q[i];
    end
  end

  // Pending logic
`ifdef INTC_LEVEL_EN
  always_comb begin
    pend_d = src;
  end
`else
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic               pend_we;
  logic               eoi_clr;

  assign pend_we = w_en && hit && (off == ADDR_W'(OFS_PEND));
  assign eoi_clr = eoi_we && (state_q == StService);
  assign rise    = src & ~src_q;

  always_comb begin
    clr = pend_we ? w_data[NUM_SRC-1:0] : '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (eoi_clr && (id_q == ID_W'(i))) clr[i] = 1'b1;
    end
    // Set is OR-ed in after the clear so a simultaneous edge wins.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= '0;
    end else begin
      src_q <= src;
    end
  end
`endif

  // Registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < int'(NUM_SRC); i++) vec_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      if (mask_we) mask_q <= w_data[NUM_SRC-1:0];
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (w_en && hit && (off == ADDR_W'(OFS_VEC + i))) vec_q[i] <= w_data;
      end
    end
  end

  // id and vector are frozen at the IDLE->REQ transition; later arrivals or
  // mask changes do not disturb the interrupt in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q      <= '0;
      vec_out_q <= '0;
    end else if ((state_q == StIdle) && win_any) begin
      id_q      <= win_id;
      vec_out_q <= win_vec;
    end
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (win_any) state_d = StReq;
      StReq:     if (id_rd)   state_d = StService;
      StService: if (eoi_we)  state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cpu_int_req = (state_q == StReq);
    cpu_int_en  = (state_q == StIdle) ? CPU_INT_EN_ON : 8'h00;
    valid       = (state_q == StReq) || (state_q == StService);
  end

  assign cpu_int_vec = vec_out_q;

  // Read mux
  always_comb begin
    r_data = '0;
    if (hit) begin
      if (off == ADDR_W'(OFS_MASK)) begin
        r_data[NUM_SRC-1:0] = mask_q;
      end else if (off == ADDR_W'(OFS_PEND)) begin
        r_data[NUM_SRC-1:0] = pend_q;
      end else if (off == ADDR_W'(OFS_ID)) begin
        r_data[7]        = valid;
        r_data[ID_W-1:0] = id_q;
      end
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (off == ADDR_W'(OFS_VEC + i)) r_data = vec_q[i];
      end
    end
  end

endmodule
